// File: rtl/oam_dma_ctrl.sv
`timescale 1ns/1ps
// oam_dma_ctrl
// Sprite-RAM DMA engine for the NES core. It watches CPU writes for the
// DMA register ($4014). When one arrives, it halts the CPU and copies the
// 256-byte page $XX00-$XXFF from system memory into sprite RAM, starting at
// the current OAM address and wrapping around. It then releases the CPU and
// pulses dma_done.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   cpu_addr_in    snooped CPU address
//   cpu_data_in    snooped CPU write data (page number on a trigger)
//   cpu_write_en   CPU write strobe
//   oam_addr_in    current OAM address ($2003), sampled at the trigger only
//   cpu_is_halted  CPU acknowledges the halt request
//   mem_busy       memory controller cannot accept a read this cycle
//   mem_rdata      read data, valid one cycle after an accepted read
//   cpu_halt       CPU halt request
//   dma_active     DMA owns the memory bus
//   mem_addr       DMA read address
//   mem_read_en    DMA read strobe
//   spram_wr_addr  sprite RAM write address
//   spram_wr_data  sprite RAM write data
//   spram_wr_en    sprite RAM write strobe
//   dma_done       one-cycle pulse at the end of a transfer
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic [7:0]  oam_addr_in,
    input  logic        cpu_is_halted,
    input  logic        mem_busy,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic        mem_read_en,
    output logic [7:0]  spram_wr_addr,
    output logic [7:0]  spram_wr_data,
    output logic        spram_wr_en,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        READ,
        WRITE,
        DONE
    } state_e;

    // Index of the final source byte. The 8-bit count wraps to 0 on the same write.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] oamPtr_q, oamPtr_d;

    logic trigger;
    assign trigger = cpu_write_en && (cpu_addr_in == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            count_q  <= 8'h00;
            oamPtr_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            count_q  <= count_d;
            oamPtr_q <= oamPtr_d;
        end
    end

    // Triggers are acted on only in IDLE. That drops any $4014 write that
    // arrives during a transfer.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        count_d  = count_q;
        oamPtr_d = oamPtr_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d   = cpu_data_in;
                    count_d  = 8'h00;
                    oamPtr_d = oam_addr_in;
                    state_d  = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (cpu_is_halted) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (!mem_busy) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d  = count_q + 8'd1;
                oamPtr_d = oamPtr_q + 8'd1;
                state_d  = (count_q == LAST_IDX) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state. The sprite RAM address and data
    // are forced to zero when no write is happening. mem_busy does not apply
    // in WRITE, because that read was already accepted.
    always_comb begin
        cpu_halt      = 1'b0;
        dma_active    = 1'b0;
        mem_addr      = {page_q, count_q};
        mem_read_en   = 1'b0;
        spram_wr_addr = 8'h00;
        spram_wr_data = 8'h00;
        spram_wr_en   = 1'b0;
        dma_done      = 1'b0;
        case (state_q)
            IDLE: begin
                mem_addr = 16'h0000;
            end
            HALT_WAIT: begin
                cpu_halt   = 1'b1;
                dma_active = 1'b1;
            end
            READ: begin
                cpu_halt    = 1'b1;
                dma_active  = 1'b1;
                mem_read_en = !mem_busy;
            end
            WRITE: begin
                cpu_halt      = 1'b1;
                dma_active    = 1'b1;
                spram_wr_en   = 1'b1;
                spram_wr_addr = oamPtr_q;
                spram_wr_data = mem_rdata;
            end
            DONE: begin
                dma_done = 1'b1;
            end
            default: begin
                mem_addr = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
`timescale 1ns/1ps
// Testbench for oam_dma_ctrl. A small memory model returns (low address byte
// ^ 8'h5A) one cycle after each accepted read. Sprite RAM writes are captured
// in a local array. Each transfer is compared cycle by cycle against an
// expected trace built from the transfer timing.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic [7:0]  oam_addr_in;
    logic        cpu_is_halted;
    logic        mem_busy;
    logic [7:0]  mem_rdata;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [7:0]  spram_wr_addr;
    logic [7:0]  spram_wr_data;
    logic        spram_wr_en;
    logic        dma_done;

    int checkCount = 0;
    int errorCount = 0;
    int writeCount = 0;
    int doneCount  = 0;
    logic clearReq = 1'b0;
    logic [7:0] spramModel [256];

    always #20 clk = ~clk;

    oam_dma_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr_in   (cpu_addr_in),
        .cpu_data_in   (cpu_data_in),
        .cpu_write_en  (cpu_write_en),
        .oam_addr_in   (oam_addr_in),
        .cpu_is_halted (cpu_is_halted),
        .mem_busy      (mem_busy),
        .mem_rdata     (mem_rdata),
        .cpu_halt      (cpu_halt),
        .dma_active    (dma_active),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .spram_wr_addr (spram_wr_addr),
        .spram_wr_data (spram_wr_data),
        .spram_wr_en   (spram_wr_en),
        .dma_done      (dma_done)
    );

    // All outputs packed into one word, so each cycle is a single comparison.
    logic [36:0] outVec;
    assign outVec = {cpu_halt, dma_active, mem_read_en, mem_addr, spram_wr_en,
                     spram_wr_addr, spram_wr_data, dma_done};

    // The memory, sprite RAM and event counters all respond on the clock edge.
    // Sprite RAM is filled with CC when a clear is requested.
    always @(posedge clk) begin
        if (mem_read_en) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
        else             mem_rdata <= 8'hEE;
        if (clearReq) begin
            for (int i = 0; i < 256; i++) spramModel[i] <= 8'hCC;
        end else if (spram_wr_en) begin
            spramModel[spram_wr_addr] <= spram_wr_data;
        end
        if (spram_wr_en) writeCount <= writeCount + 1;
        if (dma_done)    doneCount  <= doneCount + 1;
    end

    function automatic logic [36:0] mk(logic h, logic a, logic r, logic [15:0] ad,
                                       logic w, logic [7:0] wa, logic [7:0] wd, logic d);
        return {h, a, r, ad, w, wa, wd, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [36:0] observed,
                               input logic [36:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one transfer. Set busyByte to -1 for no stall, retrigAt/resetAt
    // to 0 to disable them. Reports the writes and done pulses seen.
    task automatic applyStimulus(input logic [7:0] page, input logic [7:0] oamStart,
                                 input int haltDelay, input int busyByte,
                                 input int busyCycles, input int retrigAt,
                                 input int resetAt, output int nWrites, output int nDones);
        logic [36:0] expQ[$];
        int startW, startD, stallStart, busyWrite;
        bit resetHit = 0;
        expQ.delete();
        repeat (haltDelay + 1) expQ.push_back(mk(1, 1, 0, {page, 8'h00}, 0, 8'h00, 8'h00, 0));
        for (int b = 0; b < 256; b++) begin
            logic [7:0] bb;
            bb = 8'(b);
            if (b == busyByte)
                repeat (busyCycles) expQ.push_back(mk(1, 1, 0, {page, bb}, 0, 8'h00, 8'h00, 0));
            expQ.push_back(mk(1, 1, 1, {page, bb}, 0, 8'h00, 8'h00, 0));
            expQ.push_back(mk(1, 1, 0, {page, bb}, 1, 8'(oamStart + bb), bb ^ 8'h5A, 0));
        end
        expQ.push_back(mk(0, 0, 0, {page, 8'h00}, 0, 8'h00, 8'h00, 1));
        expQ.push_back(mk(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 0));

        stallStart = haltDelay + 2 + 2 * busyByte;
        busyWrite  = haltDelay + 2 + 20 + ((busyByte >= 0 && busyByte < 10) ? busyCycles : 0) + 1;

        @(negedge clk);
        clearReq = 1'b1;
        @(negedge clk);
        clearReq      = 1'b0;
        startW        = writeCount;
        startD        = doneCount;
        cpu_write_en  = 1'b1;
        cpu_addr_in   = 16'h4014;
        cpu_data_in   = page;
        oam_addr_in   = oamStart;
        cpu_is_halted = (haltDelay == 0);
        mem_busy      = 1'b0;

        for (int k = 1; k <= expQ.size(); k++) begin
            @(negedge clk);
            cpu_write_en  = (k == retrigAt);
            cpu_data_in   = ~page;
            oam_addr_in   = oamStart ^ 8'h3C;
            cpu_is_halted = (k > haltDelay);
            mem_busy      = (busyByte >= 0) &&
                            ((k >= stallStart && k < stallStart + busyCycles) || k == busyWrite);
            if (k == resetAt) begin
                rst = 1'b0;
                #1;
                checkOutput("async reset outputs", outVec, 37'h0);
                resetHit = 1;
                break;
            end
            #1;
            checkOutput($sformatf("cycle T+%0d", k), outVec, expQ[k-1]);
        end
        cpu_write_en = 1'b0;
        mem_busy     = 1'b0;
        @(negedge clk);
        #1;
        nWrites = writeCount - startW;
        nDones  = doneCount - startD;
        if (!resetHit) begin
            for (int i = 0; i < 256; i++) begin
                checkOutput($sformatf("spram[%02h]", 8'(oamStart + 8'(i))),
                            37'(spramModel[8'(oamStart + 8'(i))]), 37'(8'(i) ^ 8'h5A));
            end
        end
    endtask

    initial begin
        int nW, nD;
        rst           = 1'b0;
        cpu_addr_in   = 16'h0000;
        cpu_data_in   = 8'h00;
        cpu_write_en  = 1'b0;
        oam_addr_in   = 8'h00;
        cpu_is_halted = 1'b1;
        mem_busy      = 1'b0;
        #1;
        checkOutput("reset outputs", outVec, 37'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] writes to other addresses in IDLE");
        @(negedge clk);
        cpu_write_en = 1'b1;
        cpu_addr_in  = 16'h4015;
        cpu_data_in  = 8'h07;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr_in  = 16'h4014;
        #1;
        checkOutput("idle other addr", outVec, 37'h0);
        @(negedge clk);
        #1;
        checkOutput("idle no strobe", outVec, 37'h0);

        $display("[TB] basic transfer page 02");
        applyStimulus(8'h02, 8'h00, 0, -1, 0, 0, 0, nW, nD);
        checkOutput("basic writes", 37'(nW), 37'd256);
        checkOutput("basic done", 37'(nD), 37'd1);

        $display("[TB] wrapping transfer from F0");
        applyStimulus(8'h03, 8'hF0, 0, -1, 0, 0, 0, nW, nD);
        checkOutput("wrap writes", 37'(nW), 37'd256);

        $display("[TB] delayed halt acknowledge");
        applyStimulus(8'h11, 8'h00, 10, -1, 0, 0, 0, nW, nD);
        checkOutput("halt done", 37'(nD), 37'd1);

        $display("[TB] memory stall at byte 5");
        applyStimulus(8'h44, 8'h08, 0, 5, 3, 0, 0, nW, nD);
        checkOutput("stall writes", 37'(nW), 37'd256);

        $display("[TB] retrigger during transfer");
        applyStimulus(8'h21, 8'h00, 0, -1, 0, 300, 0, nW, nD);
        checkOutput("retrig writes", 37'(nW), 37'd256);
        checkOutput("retrig done", 37'(nD), 37'd1);

        $display("[TB] reset at byte 100");
        applyStimulus(8'h05, 8'h20, 0, -1, 0, 0, 202, nW, nD);
        checkOutput("reset writes", 37'(nW), 37'd100);
        checkOutput("reset no done", 37'(nD), 37'd0);
        checkOutput("reset keeps byte 99", 37'(spramModel[8'h83]), 37'(8'd99 ^ 8'h5A));
        checkOutput("reset byte 100 unwritten", 37'(spramModel[8'h84]), 37'h0CC);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post-reset idle", outVec, 37'h0);
        applyStimulus(8'h06, 8'h10, 0, -1, 0, 0, 0, nW, nD);
        checkOutput("post-reset writes", 37'(nW), 37'd256);
        checkOutput("post-reset done", 37'(nD), 37'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
